// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizing for the unified-memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_IF_RD, ARB_D_RD, ARB_D_WR} arb_state_t;
    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core request/response ports and RAM bus shared by core, arbiter and memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport ram (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch and data ports; data has priority,
// a bounded starvation counter forces a fetch through.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic           CLK,
    input  logic           RSTn,
    mem_arbiter_if.slave   bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    arb_state_t state, state_nx;
    logic [3:0] starve, starve_nx;
    logic       force_if;

    always_comb begin
        force_if      = bus.if_req && starve == MAX_CNT;
        bus.if_gnt    = force_if || (bus.if_req && !bus.d_req);
        bus.d_gnt     = bus.d_req && !force_if;
        bus.mem_en    = bus.if_gnt || bus.d_gnt;
        bus.mem_we    = bus.d_gnt && bus.d_we;
        bus.mem_addr  = bus.if_gnt ? bus.if_addr : bus.d_gnt ? bus.d_addr : {ADDR_W{1'b0}};
        bus.mem_wdata = bus.d_gnt ? bus.d_wdata : {DATA_W{1'b0}};
        state_nx      = bus.if_gnt ? ARB_IF_RD : !bus.d_gnt ? ARB_IDLE : bus.d_we ? ARB_D_WR : ARB_D_RD;
        starve_nx     = (!bus.if_req || bus.if_gnt) ? 4'd0 : starve == MAX_CNT ? starve : starve + 4'd1;
        bus.if_rvalid = state == ARB_IF_RD;
        bus.d_rvalid  = state == ARB_D_RD;
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= ARB_IDLE;
            starve <= 4'd0;
        end else begin
            state  <= state_nx;
            starve <= starve_nx;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against a reference memory model with a
// scoreboard matching every read response to the grant that caused it.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0] ram [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ram_q = 32'hDEADBEEF;
    assign bus.mem_rdata = ram_q;
    always @(posedge CLK)
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else ram_q <= ram[bus.mem_addr];
        end

    exp_t q[$];
    int   losses = 0;
    logic p_if = 0, p_d = 0, p_we = 0;
    logic [9:0]  p_if_addr = 0, p_d_addr = 0;
    logic [31:0] p_wdata = 0;
    logic exp_if_gnt, exp_d_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // One clock: present pending requests, check the grant and RAM drive, advance the model.
    task automatic cycle();
        @(posedge CLK);
        #1;
        bus.if_req = p_if;  bus.if_addr = p_if_addr;
        bus.d_req = p_d;    bus.d_we = p_we;
        bus.d_addr = p_d_addr; bus.d_wdata = p_wdata;
        #1;
        exp_if_gnt = p_if && (losses == MAX_WAIT || !p_d);
        exp_d_gnt  = p_d && !exp_if_gnt;
        chk("if_gnt", bus.if_gnt, exp_if_gnt);
        chk("d_gnt", bus.d_gnt, exp_d_gnt);
        chk("mem_en", bus.mem_en, exp_if_gnt || exp_d_gnt);
        chk("mem_we", bus.mem_we, exp_d_gnt && p_we);
        chk("mem_addr", bus.mem_addr, exp_if_gnt ? p_if_addr : exp_d_gnt ? p_d_addr : 10'd0);
        chk("mem_wdata", bus.mem_wdata, exp_d_gnt ? p_wdata : 32'd0);
        if (exp_if_gnt) q.push_back('{1'b1, ref_mem[p_if_addr], cyc + 1});
        if (exp_d_gnt && p_we) ref_mem[p_d_addr] = p_wdata;
        if (exp_d_gnt && !p_we) q.push_back('{1'b0, ref_mem[p_d_addr], cyc + 1});
        losses = (!p_if || exp_if_gnt) ? 0 : losses + 1;
        if (exp_if_gnt) p_if = 0;
        if (exp_d_gnt) p_d = 0;
    endtask

    task automatic new_if(input logic [9:0] a);
        p_if = 1; p_if_addr = a;
    endtask

    task automatic new_d(input logic we, input logic [9:0] a, input logic [31:0] wd);
        p_d = 1; p_we = we; p_d_addr = a; p_wdata = wd;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        e = '{1'b0, 32'd0, 0};
        if (!RSTn) begin
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_d_rvalid", bus.d_rvalid, 0);
            chk("rst_if_rdata", bus.if_rdata, 0);
            chk("rst_d_rdata", bus.d_rdata, 0);
        end else begin
            logic e_if, e_d;
            e_if = 0; e_d = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                e_if = e.is_if;
                e_d = !e.is_if;
            end
            chk("if_rvalid", bus.if_rvalid, e_if);
            chk("d_rvalid", bus.d_rvalid, e_d);
            chk("if_rdata", bus.if_rdata, e_if ? e.data : 32'd0);
            chk("d_rdata", bus.d_rdata, e_d ? e.data : 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[4] = 32'h00500093;
        ref_mem[4] = 32'h00500093;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        repeat (3) cycle();
        #1 RSTn = 1;
        cycle();
        new_if(10'h004);
        cycle();
        chk("lone_fetch_gnt", bus.if_gnt, 1);
        cycle();
        new_d(1, 10'h010, 32'hCAFEF00D);
        cycle();
        chk("store_mem_we", bus.mem_we, 1);
        new_d(0, 10'h010, 32'd0);
        cycle();
        cycle();
        cycle();
        for (int k = 0; k < 15; k++) begin
            if (!p_if) new_if(10'($urandom_range(0, 1023)));
            if (!p_d) new_d(0, 10'($urandom_range(0, 1023)), 32'd0);
            cycle();
            chk("contention_if_gnt", bus.if_gnt, (k % 5) == 4);
            chk("contention_one_gnt", bus.if_gnt && bus.d_gnt, 0);
        end
        p_if = 0; p_d = 0;
        cycle();
        cycle();
        new_d(0, 10'h020, 32'd0);
        cycle();
        #1 RSTn = 0;
        q.delete();
        losses = 0;
        repeat (3) cycle();
        #1 RSTn = 1;
        repeat (2) cycle();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) new_if(10'($urandom_range(0, 1023)));
            else new_d(0, 10'($urandom_range(0, 1023)), 32'd0);
            cycle();
            chk("throughput_gnt", bus.if_gnt || bus.d_gnt, 1);
        end
        for (int k = 0; k < 400; k++) begin
            if (!p_if && $urandom_range(0, 2) != 0) new_if(10'($urandom_range(0, 15)));
            if (!p_d && $urandom_range(0, 2) != 0)
                new_d(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
            cycle();
        end
        p_if = 0; p_d = 0;
        repeat (3) cycle();
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port synchronous RAM between the CPU core's instruction-fetch port and its data load/store port, so both can share one unified memory. It grants at most one access per cycle and returns read data one cycle after the grant. Data accesses have priority over fetches. A starvation counter forces a fetch grant after a bounded number of consecutive data wins. The block sits between `CPU_Core` (`address_IMEM`/`address_DMEM` side) and the memory macro.

## Interface
- `ADDR_W`, 10, word address width (matches core IMEM/DMEM address width)
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, cycles a pending fetch may lose to data before it is forced through (1..15)

- `CLK` in 1: single clock, rising edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request.
- `if_addr` in `ADDR_W`: fetch address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out `DATA_W`: fetch data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: store data.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out `DATA_W`: load data.
- `mem_en` out 1: RAM access enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_wdata` out `DATA_W`: RAM write data.
- `mem_rdata` in `DATA_W`: RAM read data, valid one cycle after `mem_en` with `!mem_we`.

## Operation
- **Requester rule:** hold `*_req` high with address, `we` and `wdata` stable until `*_gnt` is seen. Values may change in the cycle after the grant.
- **Arbitration (combinational, every cycle):**
  - If `if_req && starve == MAX_WAIT`, grant fetch.
  - Else if `d_req`, grant data.
  - Else if `if_req`, grant fetch.
  - Else grant nothing.
  - `if_gnt` and `d_gnt` are never both high.
- **RAM drive:**
  - `mem_en = if_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_addr` and `mem_wdata` are muxed from the granted port.
  - When idle, `mem_addr` and `mem_wdata` are 0.
- **State register** (records the access issued last cycle):
  - `ARB_IDLE`: no grant.
  - `ARB_IF_RD`: fetch granted.
  - `ARB_D_RD`: data load granted.
  - `ARB_D_WR`: data store granted.
  - The next state is a pure function of this cycle's grant, so every state is reachable from every other state.
- **Responses:**
  - `if_rvalid = (state == ARB_IF_RD)`.
  - `d_rvalid = (state == ARB_D_RD)`.
  - `*_rdata` equals `mem_rdata` while the matching `rvalid` is high, else 0.
  - Stores produce no `rvalid`; a store is complete at its grant.
- **Starvation counter `starve`:**
  - Clears to 0 when `if_gnt` is high or `if_req` is low.
  - Increments when `if_req && !if_gnt`.
  - Saturates at `MAX_WAIT`.
- **Back-to-back:** a new grant may issue in the same cycle as a prior `rvalid`, giving full throughput of one access per cycle.

## Timing
- **Grant latency:** 0 cycles. `*_gnt` is combinational from `*_req` and `starve`.
- **Read latency:** `rvalid` is exactly 1 cycle after the grant, for one cycle. There is no backpressure, so requesters must accept the data in that cycle.
- **Reset (`RSTn` low):**
  - `state = ARB_IDLE`, `starve = 0`.
  - All `rvalid` outputs are 0, and all `rdata` outputs are 0.
  - Grants and `mem_*` outputs follow the arbitration rule. The core holds its requests low during reset.
- **Reset mid-read:** the pending `rvalid` is dropped. No late response appears after reset is released.
- **Simultaneous `if_req` and `d_req` with `starve < MAX_WAIT`:** data wins and `starve` increments.
- **Fetch forced through:** after `MAX_WAIT` consecutive data wins, fetch wins on the next cycle and `starve` returns to 0.
- **Store then load to the same address on consecutive cycles:** the load returns the stored data, given RAM write-first/read-after-write ordering across cycles.

## Structure
- **Package `mem_arb_pkg`:**
  - `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_IF_RD, ARB_D_RD, ARB_D_WR}`.
  - Default constants for `ADDR_W`, `DATA_W` and `MAX_WAIT`.
- **Sub-modules:** none. Arbitration, the state register and the counter stay flat in `mem_arbiter`; the RAM is external.

## Test plan
- **Reset:** hold `RSTn` low with `mem_rdata = 32'hDEADBEEF`, then release. Required: all `rvalid`/`rdata` outputs are 0 and the first cycle is idle.
- **Lone fetch:** `if_req = 1`, `if_addr = 10'h004`, RAM holds `32'h00500093` at that address. Required: `if_gnt` in the same cycle, then next cycle `if_rvalid = 1` and `if_rdata = 32'h00500093`.
- **Store then load:**
  - Cycle 0: store `d_addr = 10'h010`, `d_wdata = 32'hCAFEF00D`. Required: `d_gnt` and `mem_we = 1`, with no `d_rvalid` in cycle 1.
  - Cycle 1: load from the same address. Required: `d_rvalid` in cycle 2 with `32'hCAFEF00D`.
- **Contention:** `if_req` and `d_req` both held high continuously with `MAX_WAIT = 4`. Required:
  - `d_gnt` for 4 cycles, then `if_gnt` on cycle 5 with `starve` back to 0.
  - The pattern repeats.
  - `if_gnt` and `d_gnt` are never both high.
- **Reset mid-read:** grant a load, then assert `RSTn` low in the following cycle. Required: `d_rvalid` is never seen, and after release the state is `ARB_IDLE`.
- **Throughput:** alternate fetch and load requests every cycle for 8 cycles. Required: one grant per cycle, and each `rvalid` lands exactly one cycle after its grant with the correct address's data.
